// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner: hex font, dot bit
// position and output polarity handling.
package seven_seg_pkg;

  localparam int unsigned SEG_DOT = 7;

  // Active-high gfedcba patterns, entry 0 in the low bits.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_FONT[nibble];
  endfunction

  function automatic logic [7:0] apply_polarity(input logic [7:0] value, input bit active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/seven_segments_scanner_if.sv
// Display-side bundle: value/brightness controls in, anode/segment pins and frame tick out.
interface seven_segments_scanner_if #(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned BRIGHT_W = 3
);

  logic [4*DIGITS-1:0] input_hex;
  logic [DIGITS-1:0]   dots;
  logic                blank_lz;
  logic [BRIGHT_W-1:0] brightness;
  logic [DIGITS-1:0]   display_7seg_anodes;
  logic [7:0]          display_7seg_bus;
  logic                frame_tick;

  modport master (
    output input_hex, dots, blank_lz, brightness,
    input  display_7seg_anodes, display_7seg_bus, frame_tick
  );

  modport slave (
    input  input_hex, dots, blank_lz, brightness,
    output display_7seg_anodes, display_7seg_bus, frame_tick
  );

endinterface

// File: rtl/seven_segments_font.sv
// Combinational hex nibble to active-high gfedcba decode.
module seven_segments_font
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seven_segments_scanner.sv
// Time-multiplexed hex display driver with frame-synchronous capture, leading-zero
// blanking, per-slot PWM brightness and a dark first cycle in every digit slot.
module seven_segments_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS           = 3,
  parameter int unsigned CLK_HZ           = 1_000_000,
  parameter int unsigned SCAN_HZ          = 1000,
  parameter int unsigned BRIGHT_W         = 3,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk_1MHz,
  input  logic                    rst,
  seven_segments_scanner_if.slave disp
);

  localparam int unsigned PRESC = CLK_HZ / SCAN_HZ;
  localparam int unsigned SC_W  = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam int unsigned D_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SC_W-1:0]   SC_LAST    = SC_W'(PRESC - 1);
  localparam logic [D_W-1:0]    D_LAST     = D_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ANODES_OFF = {DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [7:0]        BUS_OFF    = {8{SEG_ACTIVE_LOW}};

  // The PWM needs at least one cycle per brightness step plus the dark guard cycle.
  if (PRESC < 2 ** BRIGHT_W + 1) begin : g_bad_presc
    $error("seven_segments_scanner: CLK_HZ/SCAN_HZ too small for BRIGHT_W");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seven_segments_scanner: DIGITS must be 1..8");
  end

  logic [SC_W-1:0]     sc_q, sc_d;
  logic [D_W-1:0]      d_q, d_d;
  logic                sc_last, d_last, load;

  logic [4*DIGITS-1:0] hex_sh_q;
  logic [DIGITS-1:0]   dots_sh_q;
  logic                blz_sh_q;
  logic [BRIGHT_W-1:0] bright_sh_q;

  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]          bus_q, bus_d;
  logic                frame_tick_q;

  logic [31:0]         on_raw, on_cyc;
  logic                lit;
  logic [3:0]          cur_nib;
  logic [6:0]          cur_seg;
  logic [DIGITS-1:0]   blank_vec;
  logic                zero_run;
  logic [DIGITS-1:0]   anodes_ah;
  logic [7:0]          bus_ah;

  // Slot and digit counters; the shadow load coincides with the last cycle of a frame.
  always_comb begin
    sc_last = (sc_q == SC_LAST);
    d_last  = (d_q == D_LAST);
    load    = sc_last & d_last;
    sc_d    = sc_last ? '0 : sc_q + SC_W'(1);
    d_d     = d_q;
    if (sc_last) begin
      d_d = d_last ? '0 : d_q + D_W'(1);
    end
  end

  // PWM on-time from the shadowed brightness, never below one cycle.
  always_comb begin
    on_raw = ((32'(bright_sh_q) + 32'd1) * (PRESC - 1)) >> BRIGHT_W;
    on_cyc = (on_raw == 32'd0) ? 32'd1 : on_raw;
    lit    = (sc_q != '0) && (32'(sc_q) <= on_cyc);
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run     = zero_run & (hex_sh_q[4*i +: 4] == 4'h0);
      blank_vec[i] = blz_sh_q & zero_run & (i != 0);
    end
  end

  always_comb begin
    cur_nib = hex_sh_q[4*d_q +: 4];
  end

  seven_segments_font u_font (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Output next-state; the bus is forced dark whenever no anode is enabled.
  always_comb begin
    anodes_ah = '0;
    bus_ah    = '0;
    if (lit) begin
      anodes_ah            = DIGITS'(1) << d_q;
      bus_ah[6:0]          = blank_vec[d_q] ? 7'h00 : cur_seg;
      bus_ah[SEG_DOT]      = dots_sh_q[d_q];
    end
    anodes_d = anodes_ah ^ {DIGITS{ANODE_ACTIVE_LOW}};
    bus_d    = apply_polarity(bus_ah, SEG_ACTIVE_LOW);
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      sc_q         <= '0;
      d_q          <= '0;
      hex_sh_q     <= '0;
      dots_sh_q    <= '0;
      blz_sh_q     <= 1'b0;
      bright_sh_q  <= '0;
      anodes_q     <= ANODES_OFF;
      bus_q        <= BUS_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      sc_q         <= sc_d;
      d_q          <= d_d;
      anodes_q     <= anodes_d;
      bus_q        <= bus_d;
      frame_tick_q <= load;
      if (load) begin
        hex_sh_q    <= disp.input_hex;
        dots_sh_q   <= disp.dots;
        blz_sh_q    <= disp.blank_lz;
        bright_sh_q <= disp.brightness;
      end
    end
  end

  assign disp.display_7seg_anodes = anodes_q;
  assign disp.display_7seg_bus    = bus_q;
  assign disp.frame_tick          = frame_tick_q;

endmodule

// File: tb/tb_seven_segments_scanner.sv
// Self-checking bench: every cycle's pins compared against a frame-position model.
module tb_seven_segments_scanner;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned PRESC  = 16;
  localparam int unsigned FRAME  = DIGITS * PRESC;

  logic clk_1MHz = 1'b0;
  logic rst      = 1'b1;

  seven_segments_scanner_if #(.DIGITS(3), .BRIGHT_W(3)) dif ();

  seven_segments_scanner #(
    .DIGITS           (3),
    .CLK_HZ           (160),
    .SCAN_HZ          (10),
    .BRIGHT_W         (3),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .disp     (dif)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  int checks = 0;
  int errors = 0;

  // Model state: position within the frame and the values the display is showing.
  int          pos;
  logic [11:0] sh_hex;
  logic [2:0]  sh_dots;
  logic        sh_blz;
  logic [2:0]  sh_br;
  int          lit_cnt [3];
  int          edges;
  int          first_tick;
  logic [6:0]  font [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int on_cycles(input int b);
    int v;
    v = ((b + 1) * (int'(PRESC) - 1)) / 8;
    return (v < 1) ? 1 : v;
  endfunction

  task automatic step();
    int         dig, s, nib;
    bit         lit, blank;
    logic [6:0] glyph;
    logic [2:0] exp_an;
    logic [7:0] exp_bus;
    logic       exp_tick;
    dig   = pos / int'(PRESC);
    s     = pos % int'(PRESC);
    nib   = int'((sh_hex >> (4 * dig)) & 12'hF);
    lit   = (s >= 1) && (s <= on_cycles(int'(sh_br)));
    blank = sh_blz && (dig > 0) && ((sh_hex >> (4 * dig)) == 12'h0);
    glyph = blank ? 7'h00 : font[nib];
    exp_an   = lit ? ~(3'b001 << dig) : 3'b111;
    exp_bus  = lit ? ~{sh_dots[dig], glyph} : 8'hFF;
    exp_tick = (pos == int'(FRAME) - 1);
    @(posedge clk_1MHz);
    #1;
    edges++;
    check("anodes", 32'(dif.display_7seg_anodes), 32'(exp_an));
    check("bus", 32'(dif.display_7seg_bus), 32'(exp_bus));
    check("frame_tick", 32'(dif.frame_tick), 32'(exp_tick));
    if (dif.frame_tick === 1'b1 && first_tick < 0) first_tick = edges;
    for (int i = 0; i < 3; i++) begin
      if (dif.display_7seg_anodes[i] === 1'b0) lit_cnt[i]++;
    end
    if (pos == int'(FRAME) - 1) begin
      sh_hex  = dif.input_hex;
      sh_dots = dif.dots;
      sh_blz  = dif.blank_lz;
      sh_br   = dif.brightness;
    end
    pos = (pos + 1) % int'(FRAME);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance at least one cycle, stopping right after a shadow load.
  task automatic sync_frame();
    do step(); while (pos != 0);
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 3; i++) lit_cnt[i] = 0;
  endtask

  task automatic check_cnt(input string tag, input int exp);
    for (int i = 0; i < 3; i++) check(tag, 32'(lit_cnt[i]), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_anodes", 32'(dif.display_7seg_anodes), 32'h7);
    check("reset_bus", 32'(dif.display_7seg_bus), 32'hFF);
    check("reset_tick", 32'(dif.frame_tick), 32'h0);
    @(negedge clk_1MHz);
    @(negedge clk_1MHz);
    rst        = 1'b0;
    pos        = 0;
    sh_hex     = '0;
    sh_dots    = '0;
    sh_blz     = 1'b0;
    sh_br      = '0;
    edges      = 0;
    first_tick = -1;
  endtask

  task automatic randomize_inputs();
    dif.input_hex  = 12'($urandom);
    if ($urandom_range(0, 2) == 0) dif.input_hex = 12'($urandom_range(0, 15));
    dif.dots       = 3'($urandom);
    dif.blank_lz   = 1'($urandom);
    dif.brightness = 3'($urandom);
  endtask

  initial begin
    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    dif.input_hex  = '0;
    dif.dots       = '0;
    dif.blank_lz   = 1'b0;
    dif.brightness = '0;
    repeat (3) @(negedge clk_1MHz);
    #2;
    do_reset();
    run(int'(FRAME));
    check("first_tick_edge", 32'(first_tick), 32'd48);

    // Value and font at full brightness.
    dif.input_hex  = 12'hA5C;
    dif.brightness = 3'd7;
    sync_frame();
    clear_cnt();
    run(int'(FRAME));
    check_cnt("on_b7_a5c", 15);

    // Brightness steps.
    dif.brightness = 3'd0;
    sync_frame();
    clear_cnt();
    run(int'(FRAME));
    check_cnt("on_b0", 1);
    dif.brightness = 3'd3;
    sync_frame();
    clear_cnt();
    run(int'(FRAME));
    check_cnt("on_b3", 7);
    dif.brightness = 3'd7;

    // Leading-zero blanking with a dot on a blanked digit.
    dif.input_hex = 12'h007;
    dif.blank_lz  = 1'b1;
    dif.dots      = 3'b100;
    sync_frame();
    run(int'(FRAME));
    dif.input_hex = 12'h000;
    dif.dots      = 3'b000;
    sync_frame();
    run(int'(FRAME));

    // Mid-frame change stays invisible until the next frame.
    dif.blank_lz  = 1'b0;
    dif.input_hex = 12'h111;
    sync_frame();
    run(20);
    dif.input_hex = 12'h222;
    sync_frame();
    run(int'(FRAME));

    // Random inputs changed at arbitrary cycles.
    for (int k = 0; k < 25; k++) begin
      randomize_inputs();
      run(int'($urandom_range(1, 100)));
    end

    // Inputs changed exactly on the load cycle are captured.
    for (int k = 0; k < 4; k++) begin
      while (pos != int'(FRAME) - 1) step();
      randomize_inputs();
      run(int'(FRAME) + 1);
    end

    // Reset asserted in the middle of a slot.
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      run(int'($urandom_range(5, 90)));
      do_reset();
      run(int'(FRAME) * 2);
      check("tick_after_reset", 32'(first_tick), 32'd48);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
